// File: rtl/bus_slave_mem.sv
// bus_slave_mem: serial-bus memory slave.
// Receives an LSB-first address on B_BUS_OUT and acknowledges only when the
// top ID_WIDTH address bits equal SLAVE_ID. A write stores one DATA_WIDTH
// word and presents it on S_DOUT with a one-cycle S_DVALID strobe. A read
// returns the addressed word LSB-first on B_BUS_IN. Dropping AD_SEL returns
// to idle on the next edge, and no memory write happens in that case.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   AD_SEL, B_RW        slave select, direction (1 = write)
//   B_BUS_OUT           serial data, master to slave
//   B_BUS_IN            serial read data, slave to master
//   B_ACK, B_SBSY       acknowledge, slave busy
//   S_DVALID, S_DOUT    new-word strobe and last written word
module bus_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_AW     = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned SLAVE_ID   = 0,
  parameter int unsigned ACK_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  AD_SEL,
  input  logic                  B_RW,
  input  logic                  B_BUS_OUT,
  output logic                  B_BUS_IN,
  output logic                  B_ACK,
  output logic                  B_SBSY,
  output logic                  S_DVALID,
  output logic [DATA_WIDTH-1:0] S_DOUT
);

  localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;
  localparam int unsigned MAX_AD    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned MAX_CNT   = (MAX_AD > ACK_CYCLES) ? MAX_AD : ACK_CYCLES;
  localparam int unsigned CW        = $clog2(MAX_CNT) + 1;
  localparam int unsigned DIW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, NAK_A, WR, ACK_W, RD
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rd_sh_q, rd_sh_d;
  logic                    bus_in_q, bus_in_d;
  logic                    ack_q, ack_d;
  logic                    sbsy_q, sbsy_d;
  logic                    dvalid_q, dvalid_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    commit_c;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  // Only the low MEM_AW address bits index the array; the rest alias.
  assign rd_word = mem[addr_q[MEM_AW-1:0]];

  // Word store; a reset in the commit cycle suppresses the write.
  always_ff @(posedge CLK) begin
    if (commit_c && !RST) begin
      mem[addr_q[MEM_AW-1:0]] <= wdata_d;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, bit counting and shift registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    rd_sh_d  = rd_sh_q;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        addr_d = '0;
        if (AD_SEL) state_d = ADDR;
      end
      ADDR: begin
        // LSB-first shift: after ADDR_WIDTH bits, bit k sits at position k.
        addr_d = {B_BUS_OUT, addr_q[ADDR_WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
          cnt_d = '0;
          rw_d  = B_RW;
          if (addr_d[ADDR_WIDTH-1 -: ID_WIDTH] == ID_WIDTH'(SLAVE_ID)) state_d = ACK_A;
          else                                                         state_d = NAK_A;
        end
      end
      ACK_A: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACK_CYCLES - 1)) begin
          cnt_d   = '0;
          // Bit 0 goes straight to the output flop; keep the remaining bits.
          rd_sh_d = rd_word >> 1;
          state_d = rw_q ? WR : RD;
        end
      end
      NAK_A: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WR: begin
        wdata_d[cnt_q[DIW-1:0]] = B_BUS_OUT;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d    = '0;
          commit_c = 1'b1;
          state_d  = ACK_W;
        end
      end
      ACK_W: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ACK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      RD: begin
        rd_sh_d = rd_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Deselect aborts any transfer, including a write in its final bit.
    if ((state_q != IDLE) && !AD_SEL) begin
      state_d  = IDLE;
      cnt_d    = '0;
      commit_c = 1'b0;
    end
  end

  // Output next values, derived from the state being entered.
  always_comb begin
    sbsy_d   = (state_d != IDLE);
    ack_d    = (state_d == ACK_A) || (state_d == ACK_W);
    bus_in_d = 1'b0;
    if (state_d == RD) begin
      bus_in_d = (state_q == ACK_A) ? rd_word[0] : rd_sh_q[0];
    end
    dvalid_d = commit_c;
    dout_d   = commit_c ? wdata_d : dout_q;
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      rd_sh_q  <= '0;
      bus_in_q <= 1'b0;
      ack_q    <= 1'b0;
      sbsy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      rd_sh_q  <= rd_sh_d;
      bus_in_q <= bus_in_d;
      ack_q    <= ack_d;
      sbsy_q   <= sbsy_d;
      dvalid_q <= dvalid_d;
      dout_q   <= dout_d;
    end
  end

  assign B_BUS_IN = bus_in_q;
  assign B_ACK    = ack_q;
  assign B_SBSY   = sbsy_q;
  assign S_DVALID = dvalid_q;
  assign S_DOUT   = dout_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: a default-parameter instance and a
// 16-bit-data / 3-cycle-ack instance sharing the same stimulus wires.
module tb_bus_slave_mem;

  logic CLK = 1'b0;
  logic RST, AD_SEL, B_RW, B_BUS_OUT;

  logic       d_bin, d_ack, d_sbsy, d_dv;
  logic [7:0] d_dout;
  logic        a_bin, a_ack, a_sbsy, a_dv;
  logic [15:0] a_dout;

  logic        use_alt;
  logic        o_bin, o_ack, o_sbsy, o_dv;
  logic [15:0] o_dout;

  int          n_cmp;
  int          n_fail;
  logic [15:0] model_dout;

  always #5 CLK = ~CLK;

  bus_slave_mem u_def (
    .CLK(CLK), .RST(RST), .AD_SEL(AD_SEL), .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT),
    .B_BUS_IN(d_bin), .B_ACK(d_ack), .B_SBSY(d_sbsy),
    .S_DVALID(d_dv), .S_DOUT(d_dout)
  );

  bus_slave_mem #(.DATA_WIDTH(16), .ACK_CYCLES(3)) u_alt (
    .CLK(CLK), .RST(RST), .AD_SEL(AD_SEL), .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT),
    .B_BUS_IN(a_bin), .B_ACK(a_ack), .B_SBSY(a_sbsy),
    .S_DVALID(a_dv), .S_DOUT(a_dout)
  );

  assign o_bin  = use_alt ? a_bin  : d_bin;
  assign o_ack  = use_alt ? a_ack  : d_ack;
  assign o_sbsy = use_alt ? a_sbsy : d_sbsy;
  assign o_dv   = use_alt ? a_dv   : d_dv;
  assign o_dout = use_alt ? a_dout : {8'h00, d_dout};

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [15:0] wdata;
    logic        exp_ack;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string tag, input string name,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, "sbsy",   16'(o_sbsy), 16'(0));
    chk(tag, "ack",    16'(o_ack),  16'(0));
    chk(tag, "bus_in", 16'(o_bin),  16'(0));
    chk(tag, "dvalid", 16'(o_dv),   16'(0));
    chk(tag, "dout",   o_dout,      16'(0));
  endtask

  // One transaction, starting from idle. abort_at in [0,dw) drops AD_SEL
  // in that data cycle; abort_at == dw drops it in the first ACK_W cycle.
  task automatic txn(input string tag, input logic [15:0] addr, input logic rw,
                     input logic [15:0] wdata, input logic exp_ack,
                     input logic [15:0] exp_rd, input int dw, input int ackc,
                     input int abort_at);
    logic [15:0] sh;
    @(negedge CLK);
    chk(tag, "idle_sbsy", 16'(o_sbsy), 16'(0));
    AD_SEL = 1'b1;
    B_RW   = rw;
    sh     = addr;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        chk(tag, "addr_sbsy", 16'(o_sbsy), 16'(1));
        chk(tag, "addr_ack",  16'(o_ack),  16'(0));
      end
      B_BUS_OUT = sh[0];
      sh        = sh >> 1;
    end
    for (int k = 0; k < ackc; k++) begin
      @(negedge CLK);
      B_BUS_OUT = 1'b0;
      chk(tag, "ack_win", 16'(o_ack), 16'(exp_ack));
      chk(tag, "ack_sbsy", 16'(o_sbsy), 16'(1));
    end
    if (!exp_ack) begin
      @(negedge CLK);
      chk(tag, "nak_sbsy", 16'(o_sbsy), 16'(0));
      AD_SEL = 1'b0;
      return;
    end
    if (rw) begin
      sh = wdata;
      for (int k = 0; k < dw; k++) begin
        @(negedge CLK);
        if (k == 0) chk(tag, "ack_end", 16'(o_ack), 16'(0));
        chk(tag, "wr_dvalid", 16'(o_dv), 16'(0));
        if (k == abort_at) begin
          AD_SEL = 1'b0;
          @(negedge CLK);
          chk(tag, "abt_sbsy", 16'(o_sbsy), 16'(0));
          chk(tag, "abt_dvalid", 16'(o_dv), 16'(0));
          chk(tag, "abt_dout", o_dout, model_dout);
          @(negedge CLK);
          chk(tag, "abt_dvalid2", 16'(o_dv), 16'(0));
          return;
        end
        B_BUS_OUT = sh[0];
        sh        = sh >> 1;
      end
      model_dout = wdata;
      for (int k = 0; k < ackc; k++) begin
        @(negedge CLK);
        B_BUS_OUT = 1'b0;
        chk(tag, "ackw", 16'(o_ack), 16'(1));
        chk(tag, "dvalid", 16'(o_dv), (k == 0) ? 16'(1) : 16'(0));
        if (k == 0) chk(tag, "dout", o_dout, wdata);
        if (abort_at == dw) begin
          AD_SEL = 1'b0;
          @(negedge CLK);
          chk(tag, "abtw_sbsy", 16'(o_sbsy), 16'(0));
          chk(tag, "abtw_dvalid", 16'(o_dv), 16'(0));
          chk(tag, "abtw_dout", o_dout, wdata);
          return;
        end
      end
      @(negedge CLK);
      chk(tag, "end_sbsy", 16'(o_sbsy), 16'(0));
      chk(tag, "end_dvalid", 16'(o_dv), 16'(0));
      AD_SEL = 1'b0;
    end else begin
      sh = exp_rd;
      for (int k = 0; k < dw; k++) begin
        @(negedge CLK);
        B_BUS_OUT = 1'b0;
        chk(tag, $sformatf("rd_bit%0d", k), 16'(o_bin), 16'(sh[0]));
        sh = sh >> 1;
      end
      @(negedge CLK);
      chk(tag, "end_sbsy", 16'(o_sbsy), 16'(0));
      chk(tag, "end_bus_in", 16'(o_bin), 16'(0));
      AD_SEL = 1'b0;
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    model_dout = '0;
    use_alt    = 1'b0;
    RST        = 1'b1;
    AD_SEL     = 1'b0;
    B_RW       = 1'b0;
    B_BUS_OUT  = 1'b0;

    //        addr      rw    wdata     ack   exp_rd
    vecs[0] = '{16'h0155, 1'b1, 16'h00A5, 1'b1, 16'h0000};
    vecs[1] = '{16'h0155, 1'b0, 16'h0000, 1'b1, 16'h00A5};
    vecs[2] = '{16'h4155, 1'b1, 16'h005A, 1'b0, 16'h0000};
    vecs[3] = '{16'h0155, 1'b0, 16'h0000, 1'b1, 16'h00A5};
    vecs[4] = '{16'h07FF, 1'b1, 16'h0011, 1'b1, 16'h0000};
    vecs[5] = '{16'h0FFF, 1'b1, 16'h0022, 1'b1, 16'h0000};
    vecs[6] = '{16'h07FF, 1'b0, 16'h0000, 1'b1, 16'h0022};
    vecs[7] = '{16'h3000, 1'b1, 16'h0096, 1'b1, 16'h0000};
    vecs[8] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0096};

    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].wdata,
          vecs[i].exp_ack, vecs[i].exp_rd, 8, 2, -1);
    end
    // Reading 0xC155 carries ID 3: not ours.
    txn("nak_id3", 16'hC155, 1'b0, 16'h0000, 1'b0, 16'h0000, 8, 2, -1);

    // Abort in data bit 4: no strobe, memory keeps 0xA5.
    txn("abort_wr", 16'h0155, 1'b1, 16'h003C, 1'b1, 16'h0000, 8, 2, 4);
    txn("abort_rd", 16'h0155, 1'b0, 16'h0000, 1'b1, 16'h00A5, 8, 2, -1);

    // Abort in ACK_W: write already committed.
    txn("abortw_wr", 16'h0100, 1'b1, 16'h0077, 1'b1, 16'h0000, 8, 2, 8);
    txn("abortw_rd", 16'h0100, 1'b0, 16'h0000, 1'b1, 16'h0077, 8, 2, -1);

    // Reset in the middle of the address phase.
    @(negedge CLK);
    AD_SEL = 1'b1;
    B_RW   = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      B_BUS_OUT = 1'b1;
    end
    RST = 1'b1;
    @(negedge CLK);
    check_all_zero("rst_mid");
    RST        = 1'b0;
    AD_SEL     = 1'b0;
    B_BUS_OUT  = 1'b0;
    model_dout = '0;
    txn("post_rst_wr", 16'h0155, 1'b1, 16'h00C3, 1'b1, 16'h0000, 8, 2, -1);
    txn("post_rst_rd", 16'h0155, 1'b0, 16'h0000, 1'b1, 16'h00C3, 8, 2, -1);

    // Wide-data, 3-cycle-ack instance.
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    use_alt = 1'b1;
    #1;
    check_all_zero("alt_reset");
    RST        = 1'b0;
    model_dout = '0;
    txn("alt_wr", 16'h0123, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 16, 3, -1);
    txn("alt_rd", 16'h0123, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 16, 3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_mem.md
# bus_slave_mem

Parametrised serial-bus memory slave, the next generation of the team's 2 KB bus slave. Deserialises an address LSB-first from `B_BUS_OUT`, decodes a device-ID field and acknowledges only its own ID. On a write it stores one `DATA_WIDTH` word and presents it on the local `S_DOUT`/`S_DVALID` port. On a read it returns the word serially on `B_BUS_IN`. It also handles aborts: `AD_SEL` dropping mid-transfer returns the block to idle without corrupting memory.

## Interface
- `ADDR_WIDTH`, 16: serial address length in bits; must be ≥ `MEM_AW + ID_WIDTH`.
- `MEM_AW`, 11: memory index width; depth is 2**`MEM_AW` words.
- `DATA_WIDTH`, 8: word width in bits, serialised LSB-first.
- `ID_WIDTH`, 2: device-ID field width, taken from address bits [`ADDR_WIDTH`-1 : `ADDR_WIDTH`-`ID_WIDTH`].
- `SLAVE_ID`, 0: this slave's ID value.
- `ACK_CYCLES`, 2: length of each acknowledge window in cycles (≥1).
- `CLK` in 1: single clock; everything updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `AD_SEL` in 1: slave select from the bus controller; held high for the whole transaction.
- `B_RW` in 1: transfer direction; 1 = write, 0 = read. Sampled in the last address-bit cycle.
- `B_BUS_OUT` in 1: serial data, master to slave.
- `B_BUS_IN` out 1: serial read data, slave to master.
- `B_ACK` out 1: acknowledge.
- `B_SBSY` out 1: slave busy.
- `S_DVALID` out 1: one-cycle strobe marking a newly written word.
- `S_DOUT` out `DATA_WIDTH`: last written word.

## Operation
- States: IDLE, ADDR, ACK_A, NAK_A, WR, ACK_W, RD.
- All outputs are registered.
- `B_SBSY` is 1 in every state except IDLE.
- IDLE
  - `AD_SEL`=1 moves to ADDR.
  - The bit counter and the address shift register clear to 0.
- ADDR
  - Cycle k (k = 0..`ADDR_WIDTH`-1) stores `B_BUS_OUT` into address bit k.
  - In cycle `ADDR_WIDTH`-1, `B_RW` is latched and the ID compare uses the completed address, including the bit arriving that cycle.
  - On an ID match go to ACK_A; otherwise go to NAK_A.
- ACK_A
  - `B_ACK`=1 for `ACK_CYCLES` cycles.
  - In its last cycle, `mem[addr[MEM_AW-1:0]]` is loaded into the read shift register.
  - Then go to WR if the latched RW is 1, or to RD if it is 0.
- NAK_A: `B_ACK`=0 for `ACK_CYCLES` cycles, then IDLE. No memory access.
- WR
  - Cycle k (k = 0..`DATA_WIDTH`-1) stores `B_BUS_OUT` into data bit k.
  - On the edge that ends cycle `DATA_WIDTH`-1, the full word is written to memory and `S_DOUT` is updated, with `S_DVALID`=1 in the following cycle (the first ACK_W cycle).
  - Then go to ACK_W.
- ACK_W: `B_ACK`=1 for `ACK_CYCLES` cycles, then IDLE.
- RD
  - Cycle k drives `B_BUS_IN` = read word bit k, for `DATA_WIDTH` cycles.
  - `B_BUS_IN`=0 in every other state.
  - Then go to IDLE.
- Memory index uses only the low `MEM_AW` address bits. Address bits between the index and the ID field are ignored; they wrap onto the same location.
- Abort
  - `AD_SEL`=0 in any non-IDLE state forces IDLE on the next edge.
  - An abort before the WR commit edge leaves memory, `S_DOUT` and `S_DVALID` unchanged.
  - An abort during ACK_W keeps the committed write, and the `S_DVALID` pulse still occurs.
- Reset
  - State → IDLE; `B_ACK`, `B_SBSY`, `B_BUS_IN` and `S_DVALID` → 0; `S_DOUT` → 0; counters and address → 0.
  - Memory contents are not reset.
  - Reset mid-write performs no commit.
  - Reset has priority over everything else.

## Timing
- Select edge
  - `AD_SEL` rises in cycle T0 (IDLE).
  - Address bit 0 is sampled in T1.
  - `B_SBSY` rises in T1.
- Write transaction length: `ADDR_WIDTH` + `ACK_CYCLES` + `DATA_WIDTH` + `ACK_CYCLES` cycles from T1. With the defaults, IDLE returns at T1+28.
- Read transaction length: `ADDR_WIDTH` + `ACK_CYCLES` + `DATA_WIDTH` cycles from T1. Read bit 0 appears at T1+18 with the defaults.
- Back-to-back transactions: `AD_SEL` held high after returning to IDLE starts a new ADDR one cycle later. There is a minimum of one IDLE cycle between transactions.
- Read-after-write: a read of the same location in the next transaction returns the new word. No write-to-read bypass is needed inside a single transaction.
- ID compare and the memory read must be single-cycle at the default sizes. The memory is inferred as synchronous RAM with a registered read in ACK_A.

## Test plan
- Write addr 0x0155 (ID 0), data 0xA5 → `B_ACK` high for 2 cycles after the address; `S_DVALID` pulses once with `S_DOUT`=0xA5; then a read of 0x0155 shifts out 1,0,1,0,0,1,0,1.
- Address 0x4155 (ID 1, `SLAVE_ID`=0) → `B_ACK` stays 0; `B_SBSY` drops after the 2-cycle NAK window; memory is untouched (a subsequent read of 0x0155 is unchanged).
- Write 0x3C, with `AD_SEL` dropped at data bit 4 → IDLE next cycle; no `S_DVALID`; a later read of the location returns the previous value.
- Write 0x11 to 0x07FF, then write 0x22 to 0x0FFF → a read of 0x07FF returns 0x22 (wrap on the low 11 bits).
- `RST` asserted mid-ADDR → all outputs 0 on the next edge; a following complete write and read succeed normally.
- `ACK_CYCLES`=3, `DATA_WIDTH`=16 build: write 0xBEEF, then read it back → 3-cycle ACK windows and 16-bit LSB-first readback of 0xBEEF.
